xgxs_lane_sync_ctrl: RTL and testbench
======================================

// Module: xgxs_lane_sync_ctrl
// PURPOSE
//   Per-lane synchronisation controller that sits downstream of the registered 8b/10b decode pipeline.
//   Sequences lane bring-up from decoded code-groups: hunts K28.5 commas, declares sync, tracks code errors, drops sync.
//   Passes decoded bytes downstream only while the lane is in sync.
//   Sync FSM semantics are fixed as described in BEHAVIOUR (comma-detect / acquired / hysteresis scheme).
// PARAMETERS
//   COMMA_ACQ    4   consecutive-comma count (no intervening error) needed to declare sync; legal range 2..8
//   GOOD_RECOVER 3   consecutive good code-groups that step the FSM back one SYNC_ACQ level
//   ERR_CNT_W    16  width of the saturating error counter (ERR_CNT_EN builds only)
// PORTS
//   clk          in   1        single clock for all logic
//   rst          in   1        synchronous reset, active-high
//   dec_valid    in   1        decoded code-group present this cycle
//   dec_data     in   8        decoded byte
//   dec_k        in   1        code-group is a control (K) character
//   dec_err      in   1        invalid 10b code or running-disparity error
//   lane_data    out  8        registered decoded byte
//   lane_k       out  1        registered K flag
//   lane_valid   out  1        lane_data/lane_k are valid and the lane is in sync
//   sync_ok      out  1        FSM is in any SYNC_ACQ_n state
//   sync_state   out  3        encoded FSM state, for debug
//   err_cnt      out  ERR_CNT_W  saturating dec_err count (ERR_CNT_EN builds only)
// BEHAVIOUR
//   - Reset: every output is 0. FSM goes to LOSS_OF_SYNC and all counters clear. rst has priority over all other inputs.
//   - Classification happens only when dec_valid=1. Otherwise the FSM, counters and output registers hold, and lane_valid=0.
//       comma   = dec_k & (dec_data==8'hBC) & ~dec_err
//       invalid = dec_err
//       good    = ~dec_err
//   - States: LOSS_OF_SYNC, COMMA_DET, SYNC_ACQ_1, SYNC_ACQ_2, SYNC_ACQ_3, SYNC_ACQ_4. The comma counter comma_cnt is used in COMMA_DET.
//   - LOSS_OF_SYNC: comma -> COMMA_DET with comma_cnt=1. Anything else -> stay.
//   - COMMA_DET:
//       invalid -> LOSS_OF_SYNC
//       comma with comma_cnt==COMMA_ACQ-1 -> SYNC_ACQ_1
//       other comma -> comma_cnt++
//       good non-comma -> stay, count held
//   - SYNC_ACQ_1: invalid -> SYNC_ACQ_2 with good_cnt=0. Good -> stay.
//   - SYNC_ACQ_n, n=2..4, on invalid: n<4 -> SYNC_ACQ_n+1 with good_cnt=0; n==4 -> LOSS_OF_SYNC.
//   - SYNC_ACQ_n, n=2..4, on good: good_cnt++. When it reaches GOOD_RECOVER -> SYNC_ACQ_n-1 with good_cnt=0.
//   - Commas in SYNC_ACQ_* count as good. No realignment is attempted.
//   - Latency is 1 clk. lane_data/lane_k capture the input for every dec_valid cycle.
//   - lane_valid(N+1) = dec_valid(N) & next_state(N) is SYNC_ACQ_*. The byte that completes acquisition is therefore emitted valid.
//     The byte that causes the drop to LOSS_OF_SYNC is emitted invalid.
//   - sync_ok and sync_state are registered and reflect the current state.
//   - Counters never wrap. comma_cnt is bounded by COMMA_ACQ and good_cnt by GOOD_RECOVER.
//   - Reset in mid-acquisition or while in sync returns the block to the reset state on the next edge.
// CONFIGURATION
//   XGXS_SYNC_ERR_CNT_EN defined:
//     - err_cnt port and logic are present.
//     - err_cnt increments on every dec_valid & dec_err, in any state, and saturates at all-ones.
//     - Cleared only by rst.
//   Not defined:
//     - err_cnt port is absent and no counter logic is generated. All other behaviour is identical.
// STRUCTURE
//   Package xgxs_sync_pkg holds:
//     - sync_state_e enum: LOSS_OF_SYNC=0, COMMA_DET=1, SYNC_ACQ_1..4=2..5
//     - K28_5_BYTE = 8'hBC
//     - widths for comma_cnt and good_cnt
//   One sub-module, xgxs_cg_classify: combinational comma/invalid/good decode. The FSM and output registers stay in the top.
// TESTING
//   1. rst held 3 clks with random inputs -> all outputs 0, sync_state=0.
//   2. 4 valid K28.5 then data 8'h55 -> sync_ok rises the clk after the 4th comma. That comma and the following 8'h55 come out with lane_valid=1.
//   3. 3 commas, then dec_err, then 4 commas -> sync_state returns to 0 after the error. sync_ok=1 only after the last 4 commas.
//   4. In sync, 1 error followed by 3 good -> SYNC_ACQ_2 then back to SYNC_ACQ_1. 4 errors spaced by fewer than 3 good -> LOSS_OF_SYNC with lane_valid=0 on the 4th.
//   5. In sync, dec_valid toggles 1010 -> state and lane_data hold on idle cycles, and lane_valid=0 on those cycles.
//   6. ERR_CNT_EN build with ERR_CNT_W=4 and 20 errors -> err_cnt saturates at 4'hF. rst in mid-sync -> err_cnt=0 and sync_ok=0 on the next clk.

Source files
------------

// File: rtl/xgxs_sync_pkg.sv
// rtl/xgxs_sync_pkg.sv - shared states, constants and counter widths for the XGXS lane sync controller
package xgxs_sync_pkg;

  typedef enum logic [2:0] {
    LOSS_OF_SYNC = 3'd0,
    COMMA_DET    = 3'd1,
    SYNC_ACQ_1   = 3'd2,
    SYNC_ACQ_2   = 3'd3,
    SYNC_ACQ_3   = 3'd4,
    SYNC_ACQ_4   = 3'd5
  } sync_state_e;

  localparam logic [7:0] K28_5_BYTE  = 8'hBC;
  localparam int         COMMA_CNT_W = 4;
  localparam int         GOOD_CNT_W  = 4;

  function automatic logic is_sync(input sync_state_e s);
    return (s == SYNC_ACQ_1) || (s == SYNC_ACQ_2) ||
           (s == SYNC_ACQ_3) || (s == SYNC_ACQ_4);
  endfunction

endpackage

// File: rtl/xgxs_cg_classify.sv
// rtl/xgxs_cg_classify.sv - combinational comma/invalid/good decode of one decoded code-group
module xgxs_cg_classify
  import xgxs_sync_pkg::*;
(
  input  logic [7:0] dec_data,
  input  logic       dec_k,
  input  logic       dec_err,
  output logic       comma,
  output logic       invalid,
  output logic       good
);

  assign comma   = dec_k & (dec_data == K28_5_BYTE) & ~dec_err;
  assign invalid = dec_err;
  assign good    = ~dec_err;

endmodule

// File: rtl/xgxs_lane_sync_ctrl.sv
// rtl/xgxs_lane_sync_ctrl.sv - per-lane comma-based sync FSM with gated 1-clk output stage
// Optional saturating error counter enabled by defining XGXS_SYNC_ERR_CNT_EN.
module xgxs_lane_sync_ctrl
  import xgxs_sync_pkg::*;
#(
  parameter int COMMA_ACQ    = 4,
  parameter int GOOD_RECOVER = 3
`ifdef XGXS_SYNC_ERR_CNT_EN
  ,
  parameter int ERR_CNT_W    = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  input  logic [7:0]           dec_data,
  input  logic                 dec_k,
  input  logic                 dec_err,
  output logic [7:0]           lane_data,
  output logic                 lane_k,
  output logic                 lane_valid,
  output logic                 sync_ok,
  output logic [2:0]           sync_state
`ifdef XGXS_SYNC_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam logic [COMMA_CNT_W-1:0] COMMA_LAST = COMMA_CNT_W'(COMMA_ACQ - 1);
  localparam logic [GOOD_CNT_W-1:0]  GOOD_LAST  = GOOD_CNT_W'(GOOD_RECOVER - 1);

  sync_state_e            state, state_n;
  logic [COMMA_CNT_W-1:0] comma_cnt, comma_cnt_n;
  logic [GOOD_CNT_W-1:0]  good_cnt, good_cnt_n;
  logic                   comma, invalid, good;

  xgxs_cg_classify u_classify (
    .dec_data (dec_data),
    .dec_k    (dec_k),
    .dec_err  (dec_err),
    .comma    (comma),
    .invalid  (invalid),
    .good     (good)
  );

  always_comb begin
    state_n     = state;
    comma_cnt_n = comma_cnt;
    good_cnt_n  = good_cnt;
    if (dec_valid) begin
      case (state)
        LOSS_OF_SYNC: begin
          if (comma) begin
            state_n     = COMMA_DET;
            comma_cnt_n = COMMA_CNT_W'(1);
          end
        end
        COMMA_DET: begin
          if (invalid) begin
            state_n     = LOSS_OF_SYNC;
            comma_cnt_n = '0;
          end else if (comma) begin
            if (comma_cnt == COMMA_LAST) begin
              state_n     = SYNC_ACQ_1;
              comma_cnt_n = '0;
            end else begin
              comma_cnt_n = comma_cnt + COMMA_CNT_W'(1);
            end
          end
        end
        SYNC_ACQ_1: begin
          if (invalid) begin
            state_n    = SYNC_ACQ_2;
            good_cnt_n = '0;
          end
        end
        SYNC_ACQ_2, SYNC_ACQ_3, SYNC_ACQ_4: begin
          // Each error pushes one level deeper; a run of good groups climbs one level back.
          if (invalid) begin
            good_cnt_n = '0;
            state_n    = (state == SYNC_ACQ_4) ? LOSS_OF_SYNC : sync_state_e'(state + 3'd1);
          end else if (good) begin
            if (good_cnt == GOOD_LAST) begin
              state_n    = sync_state_e'(state - 3'd1);
              good_cnt_n = '0;
            end else begin
              good_cnt_n = good_cnt + GOOD_CNT_W'(1);
            end
          end
        end
        default: begin
          state_n     = LOSS_OF_SYNC;
          comma_cnt_n = '0;
          good_cnt_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOSS_OF_SYNC;
      comma_cnt  <= '0;
      good_cnt   <= '0;
      lane_data  <= '0;
      lane_k     <= 1'b0;
      lane_valid <= 1'b0;
    end else begin
      state      <= state_n;
      comma_cnt  <= comma_cnt_n;
      good_cnt   <= good_cnt_n;
      lane_valid <= dec_valid & is_sync(state_n);
      if (dec_valid) begin
        lane_data <= dec_data;
        lane_k    <= dec_k;
      end
    end
  end

  assign sync_ok    = is_sync(state);
  assign sync_state = state;

`ifdef XGXS_SYNC_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (dec_valid && invalid && !(&err_cnt)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_xgxs_lane_sync_ctrl.sv
// tb/tb_xgxs_lane_sync_ctrl.sv - table-driven bench for xgxs_lane_sync_ctrl plus reset and err_cnt sequences
module tb_xgxs_lane_sync_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dec_valid = 1'b0;
  logic [7:0] dec_data = 8'h00;
  logic       dec_k = 1'b0;
  logic       dec_err = 1'b0;
  logic [7:0] lane_data;
  logic       lane_k;
  logic       lane_valid;
  logic       sync_ok;
  logic [2:0] sync_state;
`ifdef XGXS_SYNC_ERR_CNT_EN
  logic [3:0] err_cnt;
`endif

  always #5 clk = ~clk;

  xgxs_lane_sync_ctrl #(
    .COMMA_ACQ    (4),
    .GOOD_RECOVER (3)
`ifdef XGXS_SYNC_ERR_CNT_EN
    ,
    .ERR_CNT_W    (4)
`endif
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .dec_valid  (dec_valid),
    .dec_data   (dec_data),
    .dec_k      (dec_k),
    .dec_err    (dec_err),
    .lane_data  (lane_data),
    .lane_k     (lane_k),
    .lane_valid (lane_valid),
    .sync_ok    (sync_ok),
    .sync_state (sync_state)
`ifdef XGXS_SYNC_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       k;
    logic       e;
    logic       lv;
    logic [7:0] ld;
    logic       lk;
    logic       ok;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic k, input logic e,
                     input logic lv, input logic [7:0] ld, input logic lk, input logic ok,
                     input logic [2:0] st);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.k = k; t.e = e;
    t.lv = lv; t.ld = ld; t.lk = lk; t.ok = ok; t.st = st;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic k,
                       input logic e);
    @(negedge clk);
    rst = r; dec_valid = v; dec_data = d; dec_k = k; dec_err = e;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic lv, input logic [7:0] ld, input logic lk,
                       input logic ok, input logic [2:0] st);
    total++;
    if (lane_valid === lv && lane_data === ld && lane_k === lk && sync_ok === ok &&
        sync_state === st) begin
      passed++;
    end else begin
      $display("FAIL %s: got lv=%b ld=%h lk=%b ok=%b st=%0d, expected lv=%b ld=%h lk=%b ok=%b st=%0d",
               name, lane_valid, lane_data, lane_k, sync_ok, sync_state, lv, ld, lk, ok, st);
    end
  endtask

  initial begin
    // reset held 3 clks with active-looking inputs
    add(1, 1, 8'hBC, 1, 0,  0, 8'h00, 0, 0, 0);
    add(1, 1, 8'h55, 0, 1,  0, 8'h00, 0, 0, 0);
    add(1, 1, 8'hBC, 1, 0,  0, 8'h00, 0, 0, 0);
    // non-comma K and BC-as-data do not leave LOSS_OF_SYNC
    add(0, 1, 8'h1C, 1, 0,  0, 8'h1C, 1, 0, 0);
    add(0, 1, 8'hBC, 0, 0,  0, 8'hBC, 0, 0, 0);
    // 4 commas then 8'h55
    add(0, 1, 8'hBC, 1, 0,  0, 8'hBC, 1, 0, 1);
    add(0, 1, 8'hBC, 1, 0,  0, 8'hBC, 1, 0, 1);
    add(0, 1, 8'hBC, 1, 0,  0, 8'hBC, 1, 0, 1);
    add(0, 1, 8'hBC, 1, 0,  1, 8'hBC, 1, 1, 2);
    add(0, 1, 8'h55, 0, 0,  1, 8'h55, 0, 1, 2);
    // one error then 3 good: ACQ_2 and back to ACQ_1
    add(0, 1, 8'h00, 0, 1,  1, 8'h00, 0, 1, 3);
    add(0, 1, 8'h11, 0, 0,  1, 8'h11, 0, 1, 3);
    add(0, 1, 8'h22, 0, 0,  1, 8'h22, 0, 1, 3);
    add(0, 1, 8'h33, 0, 0,  1, 8'h33, 0, 1, 2);
    // 4 errors spaced by fewer than 3 good -> loss of sync
    add(0, 1, 8'h44, 0, 1,  1, 8'h44, 0, 1, 3);
    add(0, 1, 8'h45, 0, 0,  1, 8'h45, 0, 1, 3);
    add(0, 1, 8'h46, 0, 1,  1, 8'h46, 0, 1, 4);
    add(0, 1, 8'h47, 0, 0,  1, 8'h47, 0, 1, 4);
    add(0, 1, 8'h48, 0, 0,  1, 8'h48, 0, 1, 4);
    add(0, 1, 8'h49, 0, 1,  1, 8'h49, 0, 1, 5);
    add(0, 1, 8'h4A, 0, 1,  0, 8'h4A, 0, 0, 0);
    // re-acquire with a good data byte inside COMMA_DET (count held)
    add(0, 1, 8'hBC, 1, 0,  0, 8'hBC, 1, 0, 1);
    add(0, 1, 8'hBC, 1, 0,  0, 8'hBC, 1, 0, 1);
    add(0, 1, 8'h5A, 0, 0,  0, 8'h5A, 0, 0, 1);
    add(0, 1, 8'hBC, 1, 0,  0, 8'hBC, 1, 0, 1);
    add(0, 1, 8'hBC, 1, 0,  1, 8'hBC, 1, 1, 2);
    // dec_valid toggling 1010: idle cycles hold and gate lane_valid
    add(0, 0, 8'h77, 0, 0,  0, 8'hBC, 1, 1, 2);
    add(0, 1, 8'h66, 0, 0,  1, 8'h66, 0, 1, 2);
    add(0, 0, 8'h99, 0, 1,  0, 8'h66, 0, 1, 2);
    add(0, 1, 8'h67, 0, 0,  1, 8'h67, 0, 1, 2);
    // drop to loss of sync with 4 back-to-back errors
    add(0, 1, 8'hE0, 0, 1,  1, 8'hE0, 0, 1, 3);
    add(0, 1, 8'hE1, 0, 1,  1, 8'hE1, 0, 1, 4);
    add(0, 1, 8'hE2, 0, 1,  1, 8'hE2, 0, 1, 5);
    add(0, 1, 8'hE3, 0, 1,  0, 8'hE3, 0, 0, 0);
    // 3 commas, error, 4 commas
    add(0, 1, 8'hBC, 1, 0,  0, 8'hBC, 1, 0, 1);
    add(0, 1, 8'hBC, 1, 0,  0, 8'hBC, 1, 0, 1);
    add(0, 1, 8'hBC, 1, 0,  0, 8'hBC, 1, 0, 1);
    add(0, 1, 8'hBC, 1, 1,  0, 8'hBC, 1, 0, 0);
    add(0, 1, 8'hBC, 1, 0,  0, 8'hBC, 1, 0, 1);
    add(0, 1, 8'hBC, 1, 0,  0, 8'hBC, 1, 0, 1);
    add(0, 1, 8'hBC, 1, 0,  0, 8'hBC, 1, 0, 1);
    add(0, 1, 8'hBC, 1, 0,  1, 8'hBC, 1, 1, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].k, vecs[i].e);
      check($sformatf("vec%0d", i), vecs[i].lv, vecs[i].ld, vecs[i].lk, vecs[i].ok, vecs[i].st);
    end

    // reset while in sync, then reset in mid-acquisition
    drive(1, 1, 8'hBC, 1, 0);
    check("rst_in_sync", 0, 8'h00, 0, 0, 0);
    drive(0, 1, 8'hBC, 1, 0);
    drive(0, 1, 8'hBC, 1, 0);
    check("acq_cnt2", 0, 8'hBC, 1, 0, 1);
    drive(1, 1, 8'hBC, 1, 0);
    check("rst_mid_acq", 0, 8'h00, 0, 0, 0);
    drive(0, 1, 8'hBC, 1, 0);
    drive(0, 1, 8'hBC, 1, 0);
    drive(0, 1, 8'hBC, 1, 0);
    check("cnt_cleared_by_rst", 0, 8'hBC, 1, 0, 1);
    drive(0, 1, 8'hBC, 1, 0);
    check("reacq_after_rst", 1, 8'hBC, 1, 1, 2);

`ifdef XGXS_SYNC_ERR_CNT_EN
    drive(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 8'h00, 0, 1);
      total++;
      if (err_cnt === ((i + 1 > 15) ? 4'hF : 4'(i + 1))) passed++;
      else $display("FAIL err_cnt_%0d: got %h, expected %h", i, err_cnt,
                    (i + 1 > 15) ? 4'hF : 4'(i + 1));
    end
    drive(0, 0, 8'h00, 0, 1);
    total++;
    if (err_cnt === 4'hF) passed++;
    else $display("FAIL err_cnt_idle: got %h, expected f", err_cnt);
    for (int i = 0; i < 4; i++) drive(0, 1, 8'hBC, 1, 0);
    check("sync_before_rst", 1, 8'hBC, 1, 1, 2);
    drive(1, 1, 8'hBC, 1, 0);
    total++;
    if (err_cnt === 4'h0 && sync_ok === 1'b0) passed++;
    else $display("FAIL err_cnt_rst: got err_cnt=%h sync_ok=%b, expected 0 0", err_cnt, sync_ok);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
